// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM encoding and length-derived helpers for the FFT sequencer.
package fft_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    function automatic int half_n(int log2n);
        return 1 << (log2n - 1);
    endfunction
    function automatic int cnt_w(int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: LAT-deep valid/address delay from read issue to write-back, frozen by hold.
module fft_wb_delay #(
    parameter int AW  = 3,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          v_i,
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic          v_o,
    output logic [AW-1:0] a_o,
    output logic [AW-1:0] b_o
);
    logic [LAT-1:0]         v_q;
    logic [LAT-1:0][AW-1:0] a_q;
    logic [LAT-1:0][AW-1:0] b_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            a_q <= '0;
            b_q <= '0;
            v_o <= 1'b0;
            a_o <= '0;
            b_o <= '0;
        end else if (hold) begin
            v_o <= 1'b0;
        end else begin
            v_q[0] <= v_i;
            a_q[0] <= a_i;
            b_q[0] <= b_i;
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
            v_o <= v_q[LAT-1];
            a_o <= a_q[LAT-1];
            b_o <= b_q[LAT-1];
        end
    end
endmodule

// File: rtl/fft_bfu_seq.sv
// fft_bfu_seq: in-place radix-2 DIT butterfly sequencer; one operand pair per cycle,
// registered read/twiddle/write-back addresses, LAT-cycle drain between stages.
module fft_bfu_seq
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     hold,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [LOG2N-1:0]         rd_addr_a,
    output logic [LOG2N-1:0]         rd_addr_b,
    output logic [LOG2N-2:0]         tw_addr,
    output logic [$clog2(LOG2N)-1:0] stage,
    output logic                     real_only,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_addr_a,
    output logic [LOG2N-1:0]         wr_addr_b
);
    localparam int AW = LOG2N;
    localparam int TW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);
    localparam int DW = cnt_w(LAT);
    localparam int HN = half_n(LOG2N);

    state_t        state_q, state_d;
    logic [TW-1:0] k_q, k_d;
    logic [SW-1:0] s_q, s_d;
    logic [DW-1:0] dc_q, dc_d;
    logic [AW-1:0] kx, span, a_d, b_d;
    logic [TW-1:0] tw_d;
    logic          rd_en_d, real_only_d, busy_d, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            s_q       <= '0;
            dc_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            real_only <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            stage     <= '0;
        end else if (hold) begin
            rd_en     <= 1'b0;
            real_only <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            s_q       <= s_d;
            dc_q      <= dc_d;
            busy      <= busy_d;
            done      <= done_d;
            rd_en     <= rd_en_d;
            real_only <= real_only_d;
            rd_addr_a <= a_d;
            rd_addr_b <= b_d;
            tw_addr   <= tw_d;
            stage     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        dc_d    = dc_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                k_d     = '0;
                s_d     = '0;
            end
            RUN: if (k_q == TW'(HN - 1)) begin
                state_d = DRAIN;
                dc_d    = '0;
            end else k_d = k_q + TW'(1);
            DRAIN: if (dc_q == DW'(LAT - 1)) begin
                if (s_q == SW'(LOG2N - 1)) state_d = DONE;
                else begin
                    state_d = RUN;
                    s_d     = s_q + SW'(1);
                    k_d     = '0;
                end
            end else dc_d = dc_q + DW'(1);
            default: state_d = IDLE;
        endcase
    end

    // addresses derive from the next position so they land in the same register as rd_en
    always_comb begin
        kx          = AW'(k_d);
        span        = AW'(1) << s_d;
        a_d         = (((kx >> s_d) << s_d) << 1) | (kx & (span - AW'(1)));
        b_d         = a_d | span;
        tw_d        = TW'(kx & (span - AW'(1))) << (SW'(LOG2N - 1) - s_d);
        rd_en_d     = state_d == RUN;
        real_only_d = rd_en_d && s_d == '0;
        busy_d      = state_d == RUN || state_d == DRAIN;
        done_d      = state_d == DONE;
    end

    fft_wb_delay #(.AW(AW), .LAT(LAT)) u_wb (
        .clk (clk),
        .rst (rst),
        .hold(hold),
        .v_i (rd_en_d),
        .a_i (a_d),
        .b_i (b_d),
        .v_o (wr_en),
        .a_o (wr_addr_a),
        .b_o (wr_addr_b)
    );
endmodule

// File: tb/tb_fft_bfu_seq.sv
// tb_fft_bfu_seq: directed checks of pair order, write-back delay, hold, restart and reset abort.
module tb_fft_bfu_seq;
    logic       clk, rst, start, hold;
    logic       busy, done, rd_en, real_only, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr, stage;
    logic       busy4, done4, rd_en4, real_only4, wr_en4;
    logic [3:0] rd_addr_a4, rd_addr_b4, wr_addr_a4, wr_addr_b4;
    logic [2:0] tw_addr4;
    logic [1:0] stage4;
    int n_chk = 0;
    int n_fail = 0;
    int ea [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int eb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int et [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_bfu_seq #(.LOG2N(3), .LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .stage(stage), .real_only(real_only), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b)
    );

    fft_bfu_seq #(.LOG2N(4), .LAT(3)) dut4 (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr_a(rd_addr_a4), .rd_addr_b(rd_addr_b4), .tw_addr(tw_addr4),
        .stage(stage4), .real_only(real_only4), .wr_en(wr_en4), .wr_addr_a(wr_addr_a4),
        .wr_addr_b(wr_addr_b4)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {busy, done, rd_en, real_only, wr_en, rd_addr_a, rd_addr_b, tw_addr, stage,
                  wr_addr_a, wr_addr_b}, 0);
    endtask

    // Entered in the start cycle; runs through the expected done cycle dn.
    task automatic run8(input int hs, input int hl, input int dn, input bit ks);
        int ri = 0;
        int wi = 0;
        logic held;
        logic [2:0] pa;
        logic [6:0] e;
        logic [6:0] q[$];
        pa = rd_addr_a;
        q.push_back(7'd0);
        q.push_back(7'd0);
        for (int c = 1; c <= dn; c++) begin
            step;
            if (c == 1 && !ks) start = 0;
            held = hold;
            if (held) begin
                chk("hold_rd_en", rd_en, 0);
                chk("hold_wr_en", wr_en, 0);
                chk("hold_addr", rd_addr_a, pa);
            end else begin
                q.push_back({rd_en, rd_addr_a, rd_addr_b});
                e = q[q.size() - 3];
                chk("wr_en", wr_en, e[6]);
                if (wr_en) begin
                    chk("wr_a", wr_addr_a, e[5:3]);
                    chk("wr_b", wr_addr_b, e[2:0]);
                    wi++;
                end
                if (rd_en) begin
                    chk("rd_a", rd_addr_a, ea[ri % 12]);
                    chk("rd_b", rd_addr_b, eb[ri % 12]);
                    chk("tw", tw_addr, et[ri % 12]);
                    chk("stage", stage, (ri % 12) / 4);
                    chk("real_only", real_only, ri < 4);
                    chk("raw", wi >= 4 * ((ri % 12) / 4), 1);
                    if (hl == 0) chk("rd_cyc", c, 1 + ri + 2 * (ri / 4));
                    ri++;
                end
            end
            chk("busy", busy, c < dn);
            chk("done", done, c == dn);
            pa = rd_addr_a;
            if (c == hs) hold = 1;
            if (c == hs + hl) hold = 0;
        end
        chk("n_rd", ri, 12);
        chk("n_wr", wi, 12);
    endtask

    initial begin
        int j;
        clk = 0;
        rst = 1;
        start = 0;
        hold = 0;
        step;
        step;
        chk_zero("reset");
        rst = 0;
        step;
        start = 1;
        run8(0, 0, 19, 0);
        step;
        start = 1;
        run8(8, 3, 22, 0);
        step;
        start = 1;
        run8(0, 0, 19, 1);
        step;
        chk("cont_idle", {busy, done, rd_en}, 0);
        run8(0, 0, 19, 1);
        start = 0;
        step;
        chk("cont_end", {busy, done, rd_en}, 0);
        start = 1;
        for (int c = 1; c <= 11; c++) begin
            step;
            if (c == 1) start = 0;
        end
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        step;
        chk_zero("rst_drain");
        rst = 0;
        for (int c = 0; c < 22; c++) begin
            step;
            chk("rst_quiet", {busy, done, rd_en, wr_en}, 0);
        end
        start = 1;
        run8(0, 0, 19, 0);
        rst = 1;
        step;
        rst = 0;
        start = 1;
        j = 0;
        for (int c = 1; c <= 45; c++) begin
            step;
            if (c == 1) start = 0;
            if (rd_en4 && stage4 == 2'd3) begin
                chk("n16_a", rd_addr_a4, j);
                chk("n16_b", rd_addr_b4, j + 8);
                chk("n16_tw", tw_addr4, j);
                j++;
            end
            chk("n16_busy", busy4, c < 45);
            chk("n16_done", done4, c == 45);
        end
        chk("n16_cnt", j, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
